// File: rtl/gfx_pkg.sv
// Shared graphics definitions: GBA line geometry, BGR555 pixel layout,
// colour expansion helper and the scan-out reader state encoding.
package gfx_pkg;

    localparam int GBA_LINE_W = 240;
    localparam int GBA_LINES  = 160;

    // 15-bit colour as produced by the effects stage: B in the top bits, R in the bottom.
    typedef struct packed {
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } bgr555_t;

    // Reader states
    //   R_IDLE   | waiting for the bank under rd_bank to become full
    //   R_FETCH  | RAM read of pixel 0 in flight; output register loads at end
    //   R_STREAM | output register valid; RAM output holds the next pixel
    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_FETCH  = 2'd1,
        R_STREAM = 2'd2
    } rd_state_t;

    // Widen each 5-bit channel to 8 bits by replicating its top bits into the LSBs,
    // so full scale maps to 8'hFF and zero stays zero.
    function automatic logic [23:0] bgr555_to_rgb888(input bgr555_t c);
        return {c.r, c.r[4:2], c.g, c.g[4:2], c.b, c.b[4:2]};
    endfunction

endpackage

// File: rtl/gfx_line_ram.sv
// Two-bank line store, one write port and one registered read port.
// Addressed as {bank, x}; x spans the full XW range so LINE_W must fit in 2**XW.
module gfx_line_ram #(
    parameter int XW = 8,
    parameter int DW = 15
) (
    input  logic          clock,
    input  logic          we,
    input  logic [XW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [XW:0]   raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**(XW+1))-1];

    // Write port
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port; rdata holds its value while re is low, which the reader relies on
    // to keep the prefetched pixel during backpressure.
    always_ff @(posedge clock) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/gfx_line_buffer.sv
// Double-buffered scanline store: captures BGR555 lines from the effects stage
// and streams completed lines to scan-out as RGB888 over valid/ready.
module gfx_line_buffer
    import gfx_pkg::*;
#(
    parameter int LINE_W = GBA_LINE_W,
    parameter int XW     = 8
) (
    input  logic          clock,
    input  logic          rst_b,
    input  logic          pix_valid,
    input  logic [14:0]   pix_color,
    input  logic [XW-1:0] pix_x,
    input  logic [XW-1:0] pix_y,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [23:0]   rd_rgb,
    output logic [XW-1:0] rd_x,
    output logic [XW-1:0] rd_y,
    output logic          rd_last,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);
    localparam logic [XW-1:0] X_PRE  = XW'(LINE_W - 2);

    rd_state_t            state, state_nxt;
    logic [1:0]           full;
    logic [1:0][XW-1:0]   tag;
    logic                 wr_bank, rd_bank;

    logic                 pix_in_range, release_bank, writable;
    logic                 wr_accept, wr_drop, wr_line_done;

    logic                 ram_re;
    logic [XW:0]          ram_raddr;
    logic [14:0]          ram_rdata;
    logic                 load_first, load_next;

    assign pix_in_range = (pix_x <= X_LAST);
    assign release_bank = (state == R_STREAM) && rd_ready && (rd_x == X_LAST);
    // A bank being released this cycle can take a new pixel in the same cycle.
    assign writable     = !full[wr_bank] || (release_bank && (rd_bank == wr_bank));
    assign wr_accept    = pix_valid && pix_in_range && writable;
    assign wr_drop      = pix_valid && pix_in_range && !writable;
    assign wr_line_done = wr_accept && (pix_x == X_LAST);

    assign rd_valid = (state == R_STREAM);
    assign rd_last  = rd_valid && (rd_x == X_LAST);

    gfx_line_ram #(.XW(XW), .DW(15)) u_ram (
        .clock (clock),
        .we    (wr_accept),
        .waddr ({wr_bank, pix_x}),
        .wdata (pix_color),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Bank ownership: reader release clears, writer completion sets (set wins on the same bank).
    always_ff @(posedge clock) begin
        if (!rst_b) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (wr_line_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
        end
    end

    // Line tag captured with the last pixel; meaningless until the bank is full.
    always_ff @(posedge clock) begin
        if (wr_line_done) tag[wr_bank] <= pix_y;
    end

    // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clock) begin
        if (!rst_b)        overflow <= 1'b0;
        else if (wr_drop)  overflow <= 1'b1;
        else if (ovf_clr)  overflow <= 1'b0;
    end

    // Reader state register
    always_ff @(posedge clock) begin
        if (!rst_b) state <= R_IDLE;
        else        state <= state_nxt;
    end

    // Reader next state and RAM read control. In R_STREAM the RAM output register
    // already holds pixel rd_x+1, so each handshake loads it and fetches rd_x+2.
    always_comb begin
        state_nxt  = state;
        ram_re     = 1'b0;
        ram_raddr  = {rd_bank, {XW{1'b0}}};
        load_first = 1'b0;
        load_next  = 1'b0;
        unique case (state)
            R_IDLE: begin
                if (full[rd_bank]) begin
                    ram_re    = 1'b1;
                    state_nxt = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re     = 1'b1;
                ram_raddr  = {rd_bank, XW'(1)};
                load_first = 1'b1;
                state_nxt  = R_STREAM;
            end
            R_STREAM: begin
                if (rd_ready) begin
                    if (rd_x == X_LAST) begin
                        if (full[~rd_bank]) begin
                            ram_re    = 1'b1;
                            ram_raddr = {~rd_bank, {XW{1'b0}}};
                            state_nxt = R_FETCH;
                        end else begin
                            state_nxt = R_IDLE;
                        end
                    end else begin
                        load_next = 1'b1;
                        ram_re    = (rd_x < X_PRE);
                        ram_raddr = {rd_bank, rd_x + XW'(2)};
                    end
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    // Output register: loaded from RAM on entry to streaming and on each accepted beat.
    always_ff @(posedge clock) begin
        if (!rst_b) begin
            rd_rgb <= '0;
            rd_x   <= '0;
            rd_y   <= '0;
        end else if (load_first) begin
            rd_rgb <= bgr555_to_rgb888(bgr555_t'(ram_rdata));
            rd_x   <= '0;
            rd_y   <= tag[rd_bank];
        end else if (load_next) begin
            rd_rgb <= bgr555_to_rgb888(bgr555_t'(ram_rdata));
            rd_x   <= rd_x + XW'(1);
        end
    end

endmodule

// File: tb/tb_gfx_line_buffer.sv
// Scoreboard bench for gfx_line_buffer: expected beats are queued as lines are
// written and compared against every valid output cycle.
module tb_gfx_line_buffer;

    localparam int LINE_W = 240;
    localparam int XW     = 8;

    logic          clock = 1'b0;
    logic          rst_b;
    logic          pix_valid;
    logic [14:0]   pix_color;
    logic [XW-1:0] pix_x, pix_y;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [23:0]   rd_rgb;
    logic [XW-1:0] rd_x, rd_y;
    logic          rd_last;
    logic          overflow;
    logic          ovf_clr;

    gfx_line_buffer #(.LINE_W(LINE_W), .XW(XW)) dut (
        .clock     (clock),
        .rst_b     (rst_b),
        .pix_valid (pix_valid),
        .pix_color (pix_color),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_rgb    (rd_rgb),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_last   (rd_last),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [23:0] rgb;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_last_cyc = 0;
    int          rise_cyc = 0;
    int          seg = 0;
    bit          chk_timing = 0;
    logic        ready_lvl = 1'b0;
    bit          rand_ready = 0;
    logic [14:0] cols [LINE_W];
    logic [23:0] rgbs [LINE_W];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [14:0] c);
        int r, g, b;
        r = int'(c[4:0]);
        g = int'(c[9:5]);
        b = int'(c[14:10]);
        return 24'((r * 8 + r / 4) * 65536 + (g * 8 + g / 4) * 256 + (b * 8 + b / 4));
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < LINE_W; i++) begin
            cols[i] = 15'($urandom);
            rgbs[i] = exp_rgb(cols[i]);
        end
    endtask

    task automatic write_line(input logic [7:0] y, input int start, input bit push);
        beat_t b;
        for (int x = start; x < LINE_W; x++) begin
            @(posedge clock); #1;
            pix_valid = 1'b1;
            pix_x     = 8'(x);
            pix_y     = y;
            pix_color = cols[x];
            if (push) begin
                b.rgb  = rgbs[x];
                b.x    = 8'(x);
                b.y    = y;
                b.last = (x == LINE_W - 1);
                exp_q.push_back(b);
            end
            if (x == LINE_W - 1) wr_last_cyc = cyc;
        end
        @(posedge clock); #1;
        pix_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_valid) && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("drain_left", 48'(exp_q.size()), 48'(0));
        @(negedge clock);
    endtask

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        #1;
        rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
    end

    // Output monitor: while valid, outputs must equal the head of the scoreboard;
    // the head is popped only on a handshake, so a stall must hold the same beat.
    logic prev_stall = 1'b0;
    logic prev_valid = 1'b0;
    logic last_beat_last = 1'b0;
    int   last_beat_cyc = 0;
    int   last_beat_seg = -1;
    always @(negedge clock) begin
        beat_t e;
        if (!rst_b) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) chk("stall_valid", 48'(rd_valid), 48'(1));
            if (rd_valid && !prev_valid) rise_cyc = cyc;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 48'(1), 48'(0));
                end else begin
                    e = exp_q[0];
                    chk("rd_rgb", 48'(rd_rgb), 48'(e.rgb));
                    chk("rd_x", 48'(rd_x), 48'(e.x));
                    chk("rd_y", 48'(rd_y), 48'(e.y));
                    chk("rd_last", 48'(rd_last), 48'(e.last));
                    if (rd_ready) void'(exp_q.pop_front());
                end
                if (rd_ready) begin
                    if (chk_timing && last_beat_seg == seg) begin
                        if (rd_x != 0)
                            chk("beat_gap", 48'(cyc - last_beat_cyc), 48'(1));
                        else if (last_beat_last)
                            chk("line_bubble", 48'(cyc - last_beat_cyc), 48'(2));
                    end
                    last_beat_cyc  = cyc;
                    last_beat_seg  = seg;
                    last_beat_last = rd_last;
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_valid = rd_valid;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [14:0] a0;
        beat_t b;

        rst_b     = 1'b0;
        pix_valid = 1'b0;
        pix_color = '0;
        pix_x     = '0;
        pix_y     = '0;
        ovf_clr   = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 48'(rd_valid), 48'(0));
        chk("rst_rgb", 48'(rd_rgb), 48'(0));
        chk("rst_x", 48'(rd_x), 48'(0));
        chk("rst_y", 48'(rd_y), 48'(0));
        chk("rst_last", 48'(rd_last), 48'(0));
        chk("rst_ovf", 48'(overflow), 48'(0));
        @(posedge clock); #1;
        rst_b = 1'b1;

        // Single line, colour = x, ready held high
        ready_lvl = 1'b1;
        seg++; chk_timing = 1;
        for (int i = 0; i < LINE_W; i++) begin
            cols[i] = 15'(i);
            rgbs[i] = exp_rgb(cols[i]);
        end
        write_line(8'd5, 0, 1);
        drain(1000);
        chk("first_latency", 48'(rise_cyc - wr_last_cyc), 48'(3));

        // Colour expansion corner values
        seg++; chk_timing = 0;
        fill_rand();
        cols[0] = 15'h7FFF; rgbs[0] = 24'hFFFFFF;
        cols[1] = 15'h001F; rgbs[1] = 24'hFF0000;
        cols[2] = 15'h0421; rgbs[2] = 24'h080808;
        write_line(8'd7, 0, 1);
        drain(1000);

        // Overrun with reader stalled
        ready_lvl = 1'b0;
        seg++; chk_timing = 1;
        fill_rand();
        write_line(8'd1, 0, 1);
        fill_rand();
        write_line(8'd2, 0, 1);
        @(negedge clock);
        chk("ovf_before", 48'(overflow), 48'(0));
        fill_rand();
        write_line(8'd3, 0, 0);
        @(negedge clock);
        chk("ovf_set", 48'(overflow), 48'(1));
        @(posedge clock); #1; ovf_clr = 1'b1;
        @(posedge clock); #1; ovf_clr = 1'b0;
        @(negedge clock);
        chk("ovf_clr", 48'(overflow), 48'(0));
        @(posedge clock); #1; pix_valid = 1'b1; pix_x = 8'(LINE_W); pix_y = 8'd3;
        @(posedge clock); #1; pix_valid = 1'b0;
        @(negedge clock);
        chk("ovf_out_of_range", 48'(overflow), 48'(0));
        @(posedge clock); #1; pix_valid = 1'b1; pix_x = 8'd7; ovf_clr = 1'b1;
        @(posedge clock); #1; pix_valid = 1'b0; ovf_clr = 1'b0;
        @(negedge clock);
        chk("ovf_drop_beats_clr", 48'(overflow), 48'(1));
        @(posedge clock); #1; ovf_clr = 1'b1;
        @(posedge clock); #1; ovf_clr = 1'b0;
        ready_lvl = 1'b1;
        drain(1000);
        chk("ovf_after_drain", 48'(overflow), 48'(0));

        // Random backpressure over two lines
        seg++; chk_timing = 0;
        rand_ready = 1;
        fill_rand();
        write_line(8'd10, 0, 1);
        fill_rand();
        write_line(8'd11, 0, 1);
        drain(5000);
        rand_ready = 0;
        chk("bp_ovf", 48'(overflow), 48'(0));

        // Same-cycle release and write with both banks full
        seg++;
        ready_lvl = 1'b0;
        fill_rand();
        a0 = cols[0];
        write_line(8'd20, 0, 1);
        fill_rand();
        write_line(8'd21, 0, 1);
        fill_rand();
        cols[0] = a0 ^ 15'h5555;
        rgbs[0] = exp_rgb(cols[0]);
        ready_lvl = 1'b1;
        n = 0;
        @(negedge clock);
        while (!(rd_valid && rd_ready && rd_x == 8'(LINE_W - 1) && rd_y == 8'd20) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("bypass_sync", 48'(n < 2000), 48'(1));
        pix_valid = 1'b1; pix_x = 8'd0; pix_y = 8'd22; pix_color = cols[0];
        b.rgb = rgbs[0]; b.x = 8'd0; b.y = 8'd22; b.last = 1'b0;
        exp_q.push_back(b);
        @(posedge clock); #1; pix_valid = 1'b0;
        @(negedge clock);
        chk("bypass_ovf", 48'(overflow), 48'(0));
        write_line(8'd22, 1, 1);
        drain(2000);

        // Reset in the middle of a streamed line
        seg++;
        fill_rand();
        write_line(8'd30, 0, 1);
        n = 0;
        @(negedge clock);
        while (!(rd_valid && rd_x == 8'd100) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("rst_sync", 48'(n < 1000), 48'(1));
        rst_b = 1'b0;
        @(posedge clock); #1;
        exp_q.delete();
        @(negedge clock);
        chk("mid_rst_valid", 48'(rd_valid), 48'(0));
        chk("mid_rst_x", 48'(rd_x), 48'(0));
        chk("mid_rst_rgb", 48'(rd_rgb), 48'(0));
        chk("mid_rst_last", 48'(rd_last), 48'(0));
        @(posedge clock); #1;
        rst_b = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (rd_valid) n++;
        end
        chk("post_rst_idle", 48'(n), 48'(0));
        seg++; chk_timing = 1;
        fill_rand();
        write_line(8'd31, 0, 1);
        drain(1000);
        chk("post_rst_latency", 48'(rise_cyc - wr_last_cyc), 48'(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gfx_line_buffer.md
# gfx_line_buffer

Double-buffered scanline store downstream of the graphics pipeline's final colour output. It captures one 240-pixel line of 15-bit BGR555 colour per visible scanline from the special-effects stage and holds the completed line. It then streams the line to the video scan-out over a valid/ready handshake, expanded to RGB888. Writer and reader share one clock; the buffer absorbs the rate mismatch and flags any overrun.

## Interface
- `LINE_W`, default 240: visible pixels per line.
- `XW`, default 8: width of the x/y coordinate fields.
- `clock` in 1: system clock; all logic is on the rising edge.
- `rst_b` in 1: synchronous, active-low reset.
- `pix_valid` in 1: the colour/coordinate inputs are valid this cycle.
- `pix_color` in 15: BGR555 pixel; bits [4:0] R, [9:5] G, [14:10] B.
- `pix_x` in XW: hcount of this pixel.
- `pix_y` in XW: vcount of this pixel.
- `rd_valid` out 1: the output pixel is valid.
- `rd_ready` in 1: the scan-out accepts the pixel.
- `rd_rgb` out 24: {R8,G8,B8}; each channel is c5 followed by c5[4:2] (bit replication).
- `rd_x` out XW: x of the output pixel.
- `rd_y` out XW: line tag of the output pixel.
- `rd_last` out 1: the output pixel has x = LINE_W-1.
- `overflow` out 1: sticky; a pixel was dropped because both banks were full.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- Two banks (0/1), each LINE_W×15. Per-bank state: `full[b]` and an 8-bit `tag[b]`.
- Writer:
  - Uses pointer `wr_bank`.
  - A pixel is accepted when `pix_valid`, `pix_x < LINE_W`, and the bank is writable. Writable means `!full[wr_bank]`, or `full[wr_bank]` is being released this same cycle.
  - An accepted pixel is written at address `pix_x`. Out-of-range x is ignored silently.
  - An accepted pixel with `pix_x == LINE_W-1` sets `full[wr_bank]`, sets `tag[wr_bank] <= pix_y`, and toggles `wr_bank`.
  - Pixels need not arrive in order. Pixels a line does not provide keep stale data.
- Overflow: a valid, in-range pixel that arrives while the bank is not writable is dropped and sets `overflow`. If `ovf_clr` and a drop occur in the same cycle, the drop wins and `overflow` stays 1.
- Reader FSM, pointer `rd_bank`:
  - R_IDLE: when `full[rd_bank]`, go to R_FETCH with read address 0.
  - R_FETCH: the RAM read is in flight (1-cycle RAM). Go to R_STREAM and load the output register.
  - R_STREAM: `rd_valid` = 1.
    - Handshake `rd_valid && rd_ready` with x < LINE_W-1: advance x. The next pixel is prefetched so that back-to-back ready sustains one pixel per cycle (2-entry skid or prefetch register).
    - Handshake on the last pixel: release the bank (`full[rd_bank] <= 0`), toggle `rd_bank`, and go to R_IDLE. If the other bank is already full, go directly to R_FETCH instead.
- The output holds stable while `rd_valid && !rd_ready` (AXI-style: no retraction, no change).
- Reset: `full = 0`, `wr_bank = rd_bank = 0`, FSM to R_IDLE, `rd_valid = 0`, `rd_rgb / rd_x / rd_y = 0`, `rd_last = 0`, `overflow = 0`. RAM contents are not reset.
- Reset mid-line discards both the partial and the completed lines.

## Timing
- Write path: one pixel per cycle is sustained.
- Last pixel to `rd_valid`: `full` is set in cycle N (the cycle the last pixel is accepted). With the reader idle, `rd_valid` rises at N+3 (IDLE sees `full` at N+1, FETCH at N+2, output at N+3).
- Throughput: with `rd_ready` held high, a line of 240 pixels takes 240 consecutive `rd_valid` cycles. A following full bank adds 1 FETCH bubble.
- A release in cycle M makes the bank writable for a writer pixel in the same cycle M (bypass).
- `rd_last` is asserted coincident with `rd_valid` for x = LINE_W-1 only.

## Structure
- Shared package `gfx_pkg`:
  - constants `GBA_LINE_W = 240` and `GBA_LINES = 160`;
  - typedef `bgr555_t` (packed struct b, g, r);
  - function `bgr555_to_rgb888`.
- Sub-module `gfx_line_ram`: simple dual-port RAM, 2×LINE_W×15, with a 1-cycle registered read. Address is {bank, x}.
- The FSM, skid register and bank bookkeeping live in the top module.

## Test plan
- Single line: write x = 0..239 with colour = x and y = 5. Read with ready always high → 240 beats; the beat at x has `rd_rgb` = expansion of x. `rd_y` = 5; `rd_last` only at x = 239; first `rd_valid` 3 cycles after the x = 239 write.
- Colour expansion: pixel 15'h7FFF → 24'hFFFFFF. Pixel 15'h001F → 24'hFF0000. Pixel 15'h0421 → R = G = B = 8'h08.
- Overrun: hold `rd_ready = 0` and write lines y = 1, 2, then 3 → all line-3 pixels dropped and `overflow` = 1. Pulse `ovf_clr` → 0. Release `rd_ready` → lines 1 and 2 come out in order, with a 1-cycle bubble between them.
- Backpressure: toggle `rd_ready` randomly → the output is stable while stalled, no pixel is lost or duplicated, and each x appears exactly once.
- Same-cycle release/write: with both banks full and the first pixel of the next line arriving in the cycle bank 0's last beat is accepted → the pixel is accepted and `overflow` stays 0.
- Reset mid-stream: assert `rst_b` = 0 at read x = 100 → the next cycle has `rd_valid` = 0 and `full` = 0. A new line written after reset streams from x = 0.
